// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings used by uart_rx and uart_tx,
// plus a parity helper for the optional parity build.
// The encodings of states 0-4 match uart_tx's existing values. States added for
// the receiver use codes the transmitter does not use.
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam int BYTE_W = 8;

   // Values that already exist in uart_tx.
   localparam state_t s_IDLE          = 3'd0;
   localparam state_t s_RX_START_BIT  = 3'd1;   // mirrors s_TX_START_BIT
   localparam state_t s_RX_DATA_BITS  = 3'd2;   // mirrors s_TX_DATA_BITS
   localparam state_t s_RX_STOP_BIT   = 3'd3;   // mirrors s_TX_STOP_BIT
   localparam state_t s_CLEANUP       = 3'd4;
   // Receiver-only additions; 3'd7 is still free.
   localparam state_t s_RX_PARITY_BIT = 3'd5;
   localparam state_t s_BREAK         = 3'd6;

   // Expected parity bit for a data byte (odd = 0 gives even parity).
   function automatic logic f_parity(input logic [BYTE_W-1:0] i_Data, input logic i_Odd);
      return (^i_Data) ^ i_Odd;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin. It resets to 1 so that
// reset looks like an idle line and does not produce a false start bit.
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_Async,
   output logic o_Sync
);

   logic r_Meta;
   logic r_Sync;

   // Two-stage capture; the first stage may go metastable, the second settles it.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Meta <= 1'b1;
         r_Sync <= 1'b1;
      end else begin
         r_Meta <= i_Async;
         r_Sync <= r_Meta;
      end
   end

   assign o_Sync = r_Sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, start-bit glitch rejection,
// stop-bit checking and a BREAK hold-off after framing errors.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit (8E1/8O1)
// and the o_Rx_Parity_Err port.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 54,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic              i_Clock,
   input  logic              i_Rst_n,
   input  logic              i_Rx_Serial,
   output logic              o_Rx_DV,
   output logic [BYTE_W-1:0] o_Rx_Byte,
   output logic              o_Rx_Frame_Err,
   output logic              o_Rx_Active
`ifdef UART_RX_PARITY_EN
   ,
   output logic              o_Rx_Parity_Err
`endif
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] lp_Half = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] lp_Last = CNT_W'(CLKS_PER_BIT - 1);

   logic              r_Rx;
   state_t            r_State,     w_State_Nxt;
   logic [CNT_W-1:0]  r_Clk_Cnt,   w_Clk_Cnt_Nxt;
   logic [2:0]        r_Bit_Idx,   w_Bit_Idx_Nxt;
   logic [BYTE_W-1:0] r_Shift,     w_Shift_Nxt;
   logic [BYTE_W-1:0] r_Byte,      w_Byte_Nxt;
   logic              r_DV,        w_DV_Nxt;
   logic              r_Frame_Err, w_Frame_Err_Nxt;
   logic              r_Active,    w_Active_Nxt;
`ifdef UART_RX_PARITY_EN
   logic              r_Par_Err,   w_Par_Err_Nxt;
   logic              r_Par_Bad,   w_Par_Bad_Nxt;
`endif

   uart_rx_sync u_sync (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_Async (i_Rx_Serial),
      .o_Sync  (r_Rx)
   );

   // Next-state, counter, datapath and strobe decode; strobes default low so
   // each one lasts exactly the cycle after the deciding sample.
   always_comb begin
      w_State_Nxt     = r_State;
      w_Clk_Cnt_Nxt   = r_Clk_Cnt;
      w_Bit_Idx_Nxt   = r_Bit_Idx;
      w_Shift_Nxt     = r_Shift;
      w_Byte_Nxt      = r_Byte;
      w_DV_Nxt        = 1'b0;
      w_Frame_Err_Nxt = 1'b0;
      w_Active_Nxt    = r_Active;
`ifdef UART_RX_PARITY_EN
      w_Par_Err_Nxt   = 1'b0;
      w_Par_Bad_Nxt   = r_Par_Bad;
`endif

      case (r_State)
         s_IDLE: begin
            w_Clk_Cnt_Nxt = '0;
            w_Bit_Idx_Nxt = '0;
            if (!r_Rx) w_State_Nxt = s_RX_START_BIT;
         end

         s_RX_START_BIT: begin
            if (r_Clk_Cnt == lp_Half) begin
               w_Clk_Cnt_Nxt = '0;
               if (!r_Rx) begin
                  w_Active_Nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                  w_Par_Bad_Nxt = 1'b0;
`endif
                  w_State_Nxt  = s_RX_DATA_BITS;
               end else begin
                  // Line went back high before mid-start: a glitch, not a frame.
                  w_State_Nxt = s_IDLE;
               end
            end else begin
               w_Clk_Cnt_Nxt = r_Clk_Cnt + CNT_W'(1);
            end
         end

         s_RX_DATA_BITS: begin
            if (r_Clk_Cnt == lp_Last) begin
               w_Clk_Cnt_Nxt          = '0;
               w_Shift_Nxt[r_Bit_Idx] = r_Rx;
               if (r_Bit_Idx == 3'd7) begin
                  w_Bit_Idx_Nxt = '0;
`ifdef UART_RX_PARITY_EN
                  w_State_Nxt   = s_RX_PARITY_BIT;
`else
                  w_State_Nxt   = s_RX_STOP_BIT;
`endif
               end else begin
                  w_Bit_Idx_Nxt = r_Bit_Idx + 3'd1;
               end
            end else begin
               w_Clk_Cnt_Nxt = r_Clk_Cnt + CNT_W'(1);
            end
         end

`ifdef UART_RX_PARITY_EN
         s_RX_PARITY_BIT: begin
            if (r_Clk_Cnt == lp_Last) begin
               w_Clk_Cnt_Nxt = '0;
               w_Par_Bad_Nxt = (r_Rx != f_parity(r_Shift, PARITY_ODD));
               w_State_Nxt   = s_RX_STOP_BIT;
            end else begin
               w_Clk_Cnt_Nxt = r_Clk_Cnt + CNT_W'(1);
            end
         end
`endif

         s_RX_STOP_BIT: begin
            if (r_Clk_Cnt == lp_Last) begin
               w_Clk_Cnt_Nxt = '0;
               if (!r_Rx) begin
                  // Framing error wins over parity; park until the line idles.
                  w_Frame_Err_Nxt = 1'b1;
                  w_Active_Nxt    = 1'b0;
                  w_State_Nxt     = s_BREAK;
`ifdef UART_RX_PARITY_EN
               end else if (r_Par_Bad) begin
                  w_Par_Err_Nxt = 1'b1;
                  w_State_Nxt   = s_CLEANUP;
`endif
               end else begin
                  w_Byte_Nxt  = r_Shift;
                  w_DV_Nxt    = 1'b1;
                  w_State_Nxt = s_CLEANUP;
               end
            end else begin
               w_Clk_Cnt_Nxt = r_Clk_Cnt + CNT_W'(1);
            end
         end

         s_BREAK: begin
            w_Active_Nxt = 1'b0;
            if (r_Rx) w_State_Nxt = s_IDLE;
         end

         s_CLEANUP: begin
            w_Active_Nxt = 1'b0;
            w_State_Nxt  = s_IDLE;
         end

         default: begin
            w_Active_Nxt = 1'b0;
            w_State_Nxt  = s_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_State     <= s_IDLE;
         r_Clk_Cnt   <= '0;
         r_Bit_Idx   <= '0;
         r_Shift     <= '0;
         r_Byte      <= '0;
         r_DV        <= 1'b0;
         r_Frame_Err <= 1'b0;
         r_Active    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_Par_Err   <= 1'b0;
         r_Par_Bad   <= 1'b0;
`endif
      end else begin
         r_State     <= w_State_Nxt;
         r_Clk_Cnt   <= w_Clk_Cnt_Nxt;
         r_Bit_Idx   <= w_Bit_Idx_Nxt;
         r_Shift     <= w_Shift_Nxt;
         r_Byte      <= w_Byte_Nxt;
         r_DV        <= w_DV_Nxt;
         r_Frame_Err <= w_Frame_Err_Nxt;
         r_Active    <= w_Active_Nxt;
`ifdef UART_RX_PARITY_EN
         r_Par_Err   <= w_Par_Err_Nxt;
         r_Par_Bad   <= w_Par_Bad_Nxt;
`endif
      end
   end

   assign o_Rx_DV        = r_DV;
   assign o_Rx_Byte      = r_Byte;
   assign o_Rx_Frame_Err = r_Frame_Err;
   assign o_Rx_Active    = r_Active;
`ifdef UART_RX_PARITY_EN
   assign o_Rx_Parity_Err = r_Par_Err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives the serial line with a time-based bit
// model (asynchronous to the clock) and checks strobes and bytes.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int  CPB    = 54;
   localparam real CLK_NS = 20.0;
   localparam real BIT_NS = CPB * CLK_NS;
`ifdef UART_RX_PARITY_EN
   localparam bit  PAR_EN = 1'b1;
`else
   localparam bit  PAR_EN = 1'b0;
`endif

   logic       i_Clock     = 1'b0;
   logic       i_Rst_n     = 1'b0;
   logic       i_Rx_Serial = 1'b1;
   logic       o_Rx_DV;
   logic [7:0] o_Rx_Byte;
   logic       o_Rx_Frame_Err;
   logic       o_Rx_Active;
`ifdef UART_RX_PARITY_EN
   logic       o_Rx_Parity_Err;
`endif

   uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
      .i_Clock        (i_Clock),
      .i_Rst_n        (i_Rst_n),
      .i_Rx_Serial    (i_Rx_Serial),
      .o_Rx_DV        (o_Rx_DV),
      .o_Rx_Byte      (o_Rx_Byte),
      .o_Rx_Frame_Err (o_Rx_Frame_Err),
      .o_Rx_Active    (o_Rx_Active)
`ifdef UART_RX_PARITY_EN
      ,
      .o_Rx_Parity_Err(o_Rx_Parity_Err)
`endif
   );

   always #(CLK_NS / 2.0) i_Clock = ~i_Clock;

   // Event counters, only ever incremented here; tests compare deltas.
   int         n_dv = 0, n_ferr = 0, n_perr = 0, n_act = 0, n_overlap = 0, n_unstable = 0;
   logic [7:0] rx_q[$];
   logic [7:0] prev_byte = 8'h00;

   always @(negedge i_Clock) begin
      logic perr;
      perr = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr = o_Rx_Parity_Err;
`endif
      if (o_Rx_DV) begin
         n_dv++;
         rx_q.push_back(o_Rx_Byte);
      end
      if (o_Rx_Frame_Err) n_ferr++;
      if (perr)           n_perr++;
      if (o_Rx_Active)    n_act++;
      if (int'(o_Rx_DV) + int'(o_Rx_Frame_Err) + int'(perr) > 1) n_overlap++;
      if (i_Rst_n && !o_Rx_DV && (o_Rx_Byte != prev_byte)) n_unstable++;
      prev_byte = o_Rx_Byte;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input real ns);
      i_Rx_Serial = v;
      #(ns);
   endtask

   // One frame: start, 8 data LSB first, parity (parity build only), stop.
   // par_flip inverts the correct even parity. The line is left at stop_v.
   task automatic send(input logic [7:0] b, input real bns, input logic stop_v, input logic par_flip);
      drive_bit(1'b0, bns);
      for (int i = 0; i < 8; i++) drive_bit(b[i], bns);
      if (PAR_EN) drive_bit((^b) ^ par_flip, bns);
      drive_bit(stop_v, bns);
   endtask

   task automatic idle(input real nbits, input real bns);
      i_Rx_Serial = 1'b1;
      #(nbits * bns);
   endtask

   // Tests 1 and 2 at a given sender bit period.
   task automatic run_basic(input string tag, input real bns);
      int d0, f0, q0;
      d0 = n_dv; f0 = n_ferr;
      send(8'hA5, bns, 1'b1, 1'b0);
      idle(2.0, bns);
      check({tag, "_a5_dv"},     n_dv - d0,   1);
      check({tag, "_a5_byte"},   o_Rx_Byte,   8'hA5);
      check({tag, "_a5_ferr"},   n_ferr - f0, 0);
      check({tag, "_a5_active"}, o_Rx_Active, 0);
      d0 = n_dv; q0 = rx_q.size();
      send(8'h00, bns, 1'b1, 1'b0);
      send(8'hFF, bns, 1'b1, 1'b0);
      send(8'h55, bns, 1'b1, 1'b0);
      idle(2.0, bns);
      check({tag, "_b2b_dv"}, n_dv - d0, 3);
      if (rx_q.size() >= q0 + 3) begin
         check({tag, "_b2b_0"}, rx_q[q0],     8'h00);
         check({tag, "_b2b_1"}, rx_q[q0 + 1], 8'hFF);
         check({tag, "_b2b_2"}, rx_q[q0 + 2], 8'h55);
      end else begin
         check({tag, "_b2b_qsize"}, rx_q.size() - q0, 3);
      end
   endtask

   initial begin
      int d0, f0, a0, p0;

      // Reset state
      repeat (5) @(negedge i_Clock);
      check("rst_dv",     o_Rx_DV,        0);
      check("rst_byte",   o_Rx_Byte,      0);
      check("rst_ferr",   o_Rx_Frame_Err, 0);
      check("rst_active", o_Rx_Active,    0);
`ifdef UART_RX_PARITY_EN
      check("rst_perr",   o_Rx_Parity_Err, 0);
`endif
      i_Rst_n = 1'b1;
      idle(1.0, BIT_NS);

      // Tests 1-2 at nominal, -3% and +3% bit period
      run_basic("nom",  BIT_NS);
      run_basic("fast", BIT_NS * 0.97);
      run_basic("slow", BIT_NS * 1.03);

      // Test 3: short low glitch on idle line
      d0 = n_dv; f0 = n_ferr; a0 = n_act;
      i_Rx_Serial = 1'b0;
      repeat (10) @(posedge i_Clock);
      idle(2.0, BIT_NS);
      check("glitch_dv",     n_dv - d0,   0);
      check("glitch_ferr",   n_ferr - f0, 0);
      check("glitch_active", n_act - a0,  0);
      d0 = n_dv;
      send(8'h5A, BIT_NS, 1'b1, 1'b0);
      idle(2.0, BIT_NS);
      check("glitch_next_dv",   n_dv - d0, 1);
      check("glitch_next_byte", o_Rx_Byte, 8'h5A);

      // Test 4: bad stop bit then a long break
      d0 = n_dv; f0 = n_ferr;
      send(8'h3C, BIT_NS, 1'b0, 1'b0);
      #(20.0 * BIT_NS);
      idle(2.0, BIT_NS);
      check("ferr_count", n_ferr - f0, 1);
      check("ferr_dv",    n_dv - d0,   0);
      check("ferr_byte",  o_Rx_Byte,   8'h5A);
      d0 = n_dv;
      send(8'h81, BIT_NS, 1'b1, 1'b0);
      idle(2.0, BIT_NS);
      check("after_break_dv",   n_dv - d0, 1);
      check("after_break_byte", o_Rx_Byte, 8'h81);

      // Test 5: reset during data bit 4 of 0xF0
      drive_bit(1'b0, BIT_NS);
      for (int i = 0; i < 4; i++) drive_bit(1'b0, BIT_NS);
      i_Rx_Serial = 1'b1;
      #(BIT_NS / 2.0);
      check("mid_frame_active", o_Rx_Active, 1);
      i_Rst_n = 1'b0;
      #1;
      check("rst_mid_dv",     o_Rx_DV,        0);
      check("rst_mid_byte",   o_Rx_Byte,      0);
      check("rst_mid_ferr",   o_Rx_Frame_Err, 0);
      check("rst_mid_active", o_Rx_Active,    0);
      repeat (3) @(negedge i_Clock);
      i_Rst_n = 1'b1;
      idle(4.0, BIT_NS);
      d0 = n_dv;
      send(8'h12, BIT_NS, 1'b1, 1'b0);
      idle(2.0, BIT_NS);
      check("post_rst_dv",   n_dv - d0, 1);
      check("post_rst_byte", o_Rx_Byte, 8'h12);

      // Test 6: parity build only
      if (PAR_EN) begin
         d0 = n_dv; p0 = n_perr;
         send(8'h07, BIT_NS, 1'b1, 1'b0);
         idle(2.0, BIT_NS);
         check("par_ok_dv",   n_dv - d0,   1);
         check("par_ok_byte", o_Rx_Byte,   8'h07);
         check("par_ok_perr", n_perr - p0, 0);
         d0 = n_dv; p0 = n_perr;
         send(8'h07, BIT_NS, 1'b1, 1'b1);
         idle(2.0, BIT_NS);
         check("par_bad_perr", n_perr - p0, 1);
         check("par_bad_dv",   n_dv - d0,   0);
         check("par_bad_byte", o_Rx_Byte,   8'h07);
      end

      // Whole-run properties
      check("strobe_overlap", n_overlap,  0);
      check("byte_unstable",  n_unstable, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
